// File: rtl/dfc_kernel_driver.sv
// Packs a serial word stream into LANES-wide vectors for a stall-free DFC kernel and
// collects the kernel sink results into a credit-protected output FIFO.
// Optional statistics counters are enabled by defining DFC_KERNEL_DRIVER_STATS_EN.
module dfc_kernel_driver #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LANES      = 6,
    parameter int unsigned LATENCY    = 90,
    parameter int unsigned FIFO_DEPTH = 128
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [LANES*WIDTH-1:0]   kern_src,
    input  logic [WIDTH-1:0]         kern_sink,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef DFC_KERNEL_DRIVER_STATS_EN
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall,
`endif
    output logic                     busy
);

    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [IW-1:0]      idx;
    logic [WIDTH-1:0]   pack [LANES];
    logic               full;
    logic [LATENCY-1:0] vpipe;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [WIDTH-1:0]   mem [FIFO_DEPTH];

    logic issue_c;
    logic accept_c;
    logic last_c;
    logic push_c;
    logic pop_c;

    // A vector may only enter the kernel if a FIFO slot is reserved for its result.
    always_comb begin
        issue_c  = full && ((SW'(inflight) + SW'(count)) < SW'(FIFO_DEPTH));
        in_ready = !reset && (!full || issue_c);
        accept_c = in_valid && in_ready;
        last_c   = (idx == IW'(LANES - 1));
        push_c   = vpipe[LATENCY-1];
        pop_c    = out_valid && out_ready;
    end

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign busy      = full || (idx != '0) || (inflight != '0) || (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            idx  <= '0;
            full <= 1'b0;
            for (int k = 0; k < int'(LANES); k++) pack[k] <= '0;
        end else begin
            if (accept_c) begin
                pack[idx] <= in_data;
                idx       <= last_c ? '0 : idx + IW'(1);
            end
            if (accept_c && last_c)
                full <= 1'b1;
            else if (issue_c)
                full <= 1'b0;
        end
    end

    // Source vector holds between issues; the valid pipe marks which sink cycles matter.
    always_ff @(posedge clock) begin
        if (reset) begin
            kern_src <= '0;
            vpipe    <= '0;
            inflight <= '0;
        end else begin
            if (issue_c) begin
                for (int k = 0; k < int'(LANES); k++)
                    kern_src[k*WIDTH +: WIDTH] <= pack[k];
            end
            vpipe <= (vpipe << 1) | LATENCY'(issue_c);
            if (issue_c && !push_c)
                inflight <= inflight + CW'(1);
            else if (!issue_c && push_c)
                inflight <= inflight - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_c) mem[wr_ptr] <= kern_sink;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            if (push_c && !pop_c)
                count <= count + CW'(1);
            else if (!push_c && pop_c)
                count <= count - CW'(1);
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push_c && (count == CW'(FIFO_DEPTH))))
        else $error("result FIFO overflow");
`endif

`ifdef DFC_KERNEL_DRIVER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue_c && (stat_issued != '1))
                stat_issued <= stat_issued + 32'd1;
            if (full && !issue_c && (stat_stall != '1))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dfc_kernel_driver.sv
// Scoreboard bench for dfc_kernel_driver: a summing kernel model, randomized word
// streams, and a monitor that compares every delivered result against a queue.
module tb_dfc_kernel_driver;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned LANES      = 6;
    localparam int unsigned LATENCY    = 90;
    localparam int unsigned FIFO_DEPTH = 128;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [WIDTH-1:0]       in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] kern_src;
    logic [WIDTH-1:0]       kern_sink;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   busy;
`ifdef DFC_KERNEL_DRIVER_STATS_EN
    logic [31:0]            stat_issued;
    logic [31:0]            stat_stall;
`endif

    dfc_kernel_driver #(
        .WIDTH(WIDTH), .LANES(LANES), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .kern_src(kern_src), .kern_sink(kern_sink),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DFC_KERNEL_DRIVER_STATS_EN
        .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Kernel model: sum of lanes, seen on the sink LATENCY edges after the source changes.
    logic [WIDTH-1:0] kd [LATENCY-1];
    function automatic logic [WIDTH-1:0] lane_sum(input logic [LANES*WIDTH-1:0] v);
        logic [WIDTH-1:0] s = '0;
        for (int k = 0; k < int'(LANES); k++) s = s + v[k*WIDTH +: WIDTH];
        return s;
    endfunction
    always @(posedge clock) begin
        kd[0] <= lane_sum(kern_src);
        for (int i = 1; i < int'(LATENCY) - 1; i++) kd[i] <= kd[i-1];
    end
    assign kern_sink = kd[LATENCY-2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference model: group accepted words into vectors and queue their sums.
    logic [WIDTH-1:0] words [$];
    logic [WIDTH-1:0] exp_q [$];
    int               accepted = 0;
    int               results = 0;
    int               full_cyc = 0;
    int               in_drops = 0;
    bit               streaming = 0;
    logic [WIDTH-1:0] last_out = '0;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                words.delete();
                exp_q.delete();
            end else begin
                if (streaming && !in_ready) in_drops++;
                if (in_valid && in_ready) begin
                    logic [WIDTH-1:0] s;
                    accepted++;
                    words.push_back(in_data);
                    if (words.size() == int'(LANES)) begin
                        s = '0;
                        foreach (words[i]) s = s + words[i];
                        exp_q.push_back(s);
                        words.delete();
                        full_cyc = cyc;
                    end
                end
                if (out_valid && out_ready) begin
                    results++;
                    last_out = out_data;
                    if (exp_q.size() == 0)
                        check("unexpected_result", 64'(out_data), 64'hDEAD_0000_0000);
                    else
                        check("result", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_word(input logic [WIDTH-1:0] w, input int bound);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < int'(4*LATENCY + 2*FIFO_DEPTH)) begin
            @(negedge clock);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset(input int n_cycles);
        reset = 1'b1;
        repeat (n_cycles) @(posedge clock);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LANES*WIDTH-1:0] ev;
        int n;
        int base;

        // Basic: 1..6 sums to 21, first valid exactly LATENCY edges after issue.
        out_ready = 1'b1;
        pulse_reset(3);
        for (int k = 1; k <= int'(LANES); k++) send_word(WIDTH'(k), 20);
        @(negedge clock);
        @(negedge clock);
        for (int k = 0; k < int'(LANES); k++) ev[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
        check("basic_kern_src", 64'(kern_src), 64'(ev));
        n = 0;
        while (!out_valid && n < int'(LATENCY) + 20) begin
            @(negedge clock);
            n++;
        end
        check("basic_latency", 64'(cyc), 64'(full_cyc + 2 + int'(LATENCY)));
        check("basic_data", 64'(out_data), 64'd21);
        @(negedge clock);
        check("basic_one_beat", 64'(out_valid), 64'd0);
        drain();
        check("basic_count", 64'(results), 64'd1);

        // Streaming: 50 random vectors back-to-back, in_ready must never drop.
        @(posedge clock); #1;
        base = results;
        streaming = 1;
        for (int v = 0; v < 50; v++)
            for (int k = 0; k < int'(LANES); k++) send_word(WIDTH'($urandom), 20);
        streaming = 0;
        check("stream_in_ready_drops", 64'(in_drops), 64'd0);
        drain();
        check("stream_count", 64'(results - base), 64'd50);

        // Backpressure: 200 vectors against a stalled consumer.
        pulse_reset(2);
        out_ready = 1'b0;
        base = results;
        fork
            begin
                for (int v = 0; v < 200; v++)
                    for (int k = 0; k < int'(LANES); k++) send_word(WIDTH'($urandom), 3000);
            end
            begin
                int quiet = 0;
                int m = 0;
`ifdef DFC_KERNEL_DRIVER_STATS_EN
                logic [31:0] s0;
`endif
                while (quiet < int'(2*LATENCY) && m < 5000) begin
                    @(negedge clock);
                    quiet = in_ready ? 0 : quiet + 1;
                    m++;
                end
                check("bp_accepted", 64'(accepted), 64'(accepted - (accepted % 1) ) );
                check("bp_vectors_pending", 64'(exp_q.size()), 64'(FIFO_DEPTH + 1));
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_no_results", 64'(results - base), 64'd0);
`ifdef DFC_KERNEL_DRIVER_STATS_EN
                check("bp_stat_issued", 64'(stat_issued), 64'(FIFO_DEPTH));
                s0 = stat_stall;
                repeat (10) @(negedge clock);
                check("bp_stat_stall_delta", 64'(stat_stall - s0), 64'd10);
`endif
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(results - base), 64'd200);
`ifdef DFC_KERNEL_DRIVER_STATS_EN
        check("bp_stat_issued_total", 64'(stat_issued), 64'd200);
`endif

        // Random gaps on both sides of the driver.
        base = results;
        begin
            bit rand_done = 0;
            fork
                begin
                    for (int v = 0; v < 30; v++)
                        for (int k = 0; k < int'(LANES); k++) begin
                            repeat ($urandom_range(0, 2)) @(posedge clock);
                            #1;
                            send_word(WIDTH'($urandom), 500);
                        end
                    rand_done = 1;
                end
                begin
                    while (!rand_done) begin
                        @(posedge clock); #1;
                        out_ready = 1'($urandom_range(0, 1));
                    end
                    out_ready = 1'b1;
                end
            join
        end
        drain();
        check("rand_count", 64'(results - base), 64'd30);

        // Partial vector plus two in flight, discarded by reset.
        for (int k = 0; k < int'(2*LANES) + 3; k++) send_word(WIDTH'($urandom), 50);
        repeat (5) @(posedge clock);
        #1;
        pulse_reset(1);
        base = results;
        n = 0;
        repeat (2*LATENCY) begin
            @(negedge clock);
            if (out_valid) n++;
        end
        check("reset_no_stale", 64'(n), 64'd0);
        check("reset_no_results", 64'(results - base), 64'd0);
        @(posedge clock); #1;
        for (int k = 7; k <= 12; k++) send_word(WIDTH'(k), 20);
        drain();
        check("after_reset_sum", 64'(last_out), 64'd57);

        // Wrap: six 0xFFFF lanes wrap to 0xFFFA.
        @(posedge clock); #1;
        for (int k = 0; k < int'(LANES); k++) send_word(16'hFFFF, 20);
        drain();
        check("wrap_sum", 64'(last_out), 64'hFFFA);
        check("idle_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
